// File: rtl/timer_pkg.sv
// Shared definitions for the machine timer: register offsets, CTRL/STATUS bit
// positions, the trap-tracking state enum and the register address decode helper.
package timer_pkg;

  localparam logic [7:0] OFF_MTIME    = 8'h00;
  localparam logic [7:0] OFF_MTIMECMP = 8'h04;
  localparam logic [7:0] OFF_CTRL     = 8'h08;
  localparam logic [7:0] OFF_PRESCALE = 8'h0C;
  localparam logic [7:0] OFF_STATUS   = 8'h10;
  localparam logic [7:0] OFF_IRQCOUNT = 8'h14;

  localparam int CTRL_ENABLE     = 0;
  localparam int CTRL_IRQ_ENABLE = 1;
  localparam int CTRL_AUTORELOAD = 2;

  localparam int STATUS_PENDING    = 0;
  localparam int STATUS_IN_HANDLER = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HANDLER = 2'd2
  } timer_state_t;

  // Compares a word address (byte address bits [31:2]) against base + offset.
  function automatic logic reg_hit(logic [29:0] word_addr, logic [31:0] base, logic [7:0] off);
    return word_addr == 30'((base + {24'd0, off}) >> 2);
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescale divider: emits a one-cycle tick every divide+1 enabled
// cycles. A synchronous clear restarts the count and suppresses that cycle's tick.
module timer_prescaler #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] divide,
  input  logic                      clear,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] r_count;
  logic                      w_wrap;

  assign w_wrap = (r_count == divide);
  // A bus write to MTIME overrides the tick so the written value is held.
  assign tick   = enable && w_wrap && !clear;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= w_wrap ? '0 : r_count + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/machine_timer.sv
// Memory-mapped machine timer driving the controller's timerInterrupt input.
// Define TIMER_IRQ_COUNT_EN to add the saturating IRQCOUNT register at offset 0x14.
module machine_timer
  import timer_pkg::*;
#(
  parameter int          COUNTER_WIDTH  = 32,
  parameter int          PRESCALE_WIDTH = 16,
  parameter logic [31:0] BASE_ADDRESS   = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [31:0] busAddress,
  input  logic [31:0] busWriteData,
  input  logic        busWriteEnable,
  output logic [31:0] busReadData,
  input  logic        isTrap,
  input  logic        isReturn,
  output logic        timerInterrupt,
  output logic [1:0]  dbgState
);

  logic [COUNTER_WIDTH-1:0]  r_mtime;
  logic [COUNTER_WIDTH-1:0]  r_mtimecmp;
  logic [2:0]                r_ctrl;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic                      r_pending;
  logic                      r_irq;
  timer_state_t              r_state;

  logic w_sel_mtime, w_sel_mtimecmp, w_sel_ctrl, w_sel_prescale, w_sel_status;
  logic w_wr_mtime, w_wr_mtimecmp, w_wr_ctrl, w_wr_prescale, w_wr_status;
  logic w_tick, w_match, w_took, w_clear_pending, w_unused;
  logic [31:0] w_read_data;

  assign w_sel_mtime    = reg_hit(busAddress[31:2], BASE_ADDRESS, OFF_MTIME);
  assign w_sel_mtimecmp = reg_hit(busAddress[31:2], BASE_ADDRESS, OFF_MTIMECMP);
  assign w_sel_ctrl     = reg_hit(busAddress[31:2], BASE_ADDRESS, OFF_CTRL);
  assign w_sel_prescale = reg_hit(busAddress[31:2], BASE_ADDRESS, OFF_PRESCALE);
  assign w_sel_status   = reg_hit(busAddress[31:2], BASE_ADDRESS, OFF_STATUS);

  assign w_wr_mtime    = busWriteEnable && w_sel_mtime;
  assign w_wr_mtimecmp = busWriteEnable && w_sel_mtimecmp;
  assign w_wr_ctrl     = busWriteEnable && w_sel_ctrl;
  assign w_wr_prescale = busWriteEnable && w_sel_prescale;
  assign w_wr_status   = busWriteEnable && w_sel_status;

  assign w_unused = &{1'b0, busAddress[1:0]};

  timer_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk   (clk),
    .rstN  (rstN),
    .enable(r_ctrl[CTRL_ENABLE]),
    .divide(r_prescale),
    .clear (w_wr_mtime),
    .tick  (w_tick)
  );

  assign w_match         = w_tick && (r_mtime == r_mtimecmp);
  assign w_took          = (r_state == ASSERT) && isTrap;
  assign w_clear_pending = w_took || (w_wr_status && busWriteData[STATUS_PENDING]);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_ctrl     <= '0;
      r_prescale <= '0;
      r_pending  <= 1'b0;
    end else begin
      if (w_wr_mtime) begin
        r_mtime <= busWriteData[COUNTER_WIDTH-1:0];
      end else if (w_tick) begin
        r_mtime <= (w_match && r_ctrl[CTRL_AUTORELOAD]) ? '0 : r_mtime + COUNTER_WIDTH'(1);
      end
      if (w_wr_mtimecmp) r_mtimecmp <= busWriteData[COUNTER_WIDTH-1:0];
      if (w_wr_ctrl)     r_ctrl     <= busWriteData[2:0];
      if (w_wr_prescale) r_prescale <= busWriteData[PRESCALE_WIDTH-1:0];
      // A new compare match outranks any clear in the same cycle.
      if (w_match) begin
        r_pending <= 1'b1;
      end else if (w_clear_pending) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Trap tracking: request once, then stay masked until mret.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= IDLE;
      r_irq   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_pending && r_ctrl[CTRL_IRQ_ENABLE]) begin
            r_state <= ASSERT;
            r_irq   <= 1'b1;
          end
        end
        ASSERT: begin
          if (isTrap) begin
            r_state <= HANDLER;
            r_irq   <= 1'b0;
          end else if (!r_ctrl[CTRL_IRQ_ENABLE]) begin
            r_state <= IDLE;
            r_irq   <= 1'b0;
          end
        end
        HANDLER: begin
          if (isReturn) r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

`ifdef TIMER_IRQ_COUNT_EN
  logic        w_sel_irqcount;
  logic [15:0] r_irq_count;

  assign w_sel_irqcount = reg_hit(busAddress[31:2], BASE_ADDRESS, OFF_IRQCOUNT);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_irq_count <= '0;
    end else if (busWriteEnable && w_sel_irqcount) begin
      r_irq_count <= '0;
    end else if (w_took && (r_irq_count != 16'hFFFF)) begin
      r_irq_count <= r_irq_count + 16'd1;
    end
  end
`endif

  always_comb begin
    w_read_data = '0;
    if (w_sel_mtime)    w_read_data = 32'(r_mtime);
    if (w_sel_mtimecmp) w_read_data = 32'(r_mtimecmp);
    if (w_sel_ctrl)     w_read_data = {29'd0, r_ctrl};
    if (w_sel_prescale) w_read_data = 32'(r_prescale);
    if (w_sel_status)   w_read_data = {30'd0, r_state == HANDLER, r_pending};
`ifdef TIMER_IRQ_COUNT_EN
    if (w_sel_irqcount) w_read_data = {16'd0, r_irq_count};
`endif
  end

  assign busReadData    = w_read_data;
  assign timerInterrupt = r_irq;
  assign dbgState       = r_state;

endmodule
